// File: rtl/quadrature_encoder_emulator.sv
// Rotary-encoder emulator: turns detent commands into a Gray-coded A/B
// quadrature trace and press requests into a timed push-switch pulse.
module quadrature_encoder_emulator #(
  parameter int unsigned DWELL        = 4,
  parameter int unsigned PRESS_CYCLES = 16
) (
  input  logic       clk100Mhz,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_count,
  input  logic       cmd_dir,
  input  logic       press_req,
  output logic       enc_phase_a,
  output logic       enc_phase_b,
  output logic       enc_switch,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_PRESS  = 2'd2
  } state_e;

  localparam logic [7:0]  DWELL_L = 8'(DWELL);
  localparam logic [15:0] PRESS_L = 16'(PRESS_CYCLES);

  state_e      state_q;
  logic [7:0]  rem_q;
  logic [1:0]  idx_q;
  logic [7:0]  dwell_q;
  logic [15:0] press_cnt_q;
  logic        dir_q;
  logic        a_q;
  logic        b_q;
  logic        sw_q;
  logic        busy_q;
  logic        done_q;
  logic        ready_q;
  logic        zero_pend_q;

  logic [1:0]  idx_d;
  logic [7:0]  rem_d;
  logic        lead_d;
  logic        lag_d;
  logic        a_d;
  logic        b_d;

  // idx is the position in the 4-state cycle (0 = 00). The leading phase is
  // high at positions 1 and 2, the lagging one at 2 and 3; direction swaps them.
  always_comb begin
    idx_d  = idx_q + 2'd1;
    rem_d  = rem_q;
    if (idx_q == 2'd3) begin
      rem_d = rem_q - 8'd1;
    end
    lead_d = (idx_d == 2'd1) || (idx_d == 2'd2);
    lag_d  = (idx_d == 2'd2) || (idx_d == 2'd3);
    a_d    = dir_q ? lag_d : lead_d;
    b_d    = dir_q ? lead_d : lag_d;
  end

  always_ff @(posedge clk100Mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= 8'd0;
      idx_q       <= 2'd0;
      dwell_q     <= 8'd0;
      press_cnt_q <= 16'd0;
      dir_q       <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      sw_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      // A zero-detent command finishes one cycle after acceptance without leaving IDLE.
      done_q      <= zero_pend_q;
      zero_pend_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && cmd_valid) begin
            if (cmd_count == 8'd0) begin
              zero_pend_q <= 1'b1;
            end else begin
              state_q <= ST_ROTATE;
              rem_q   <= cmd_count;
              dir_q   <= cmd_dir;
              idx_q   <= 2'd0;
              dwell_q <= 8'd1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end else if (ready_q && press_req) begin
            state_q     <= ST_PRESS;
            press_cnt_q <= PRESS_L;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        ST_ROTATE: begin
          if (dwell_q == 8'd1) begin
            if (rem_q == 8'd0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              rem_q   <= rem_d;
              a_q     <= a_d;
              b_q     <= b_d;
              dwell_q <= DWELL_L;
            end
          end else begin
            dwell_q <= dwell_q - 8'd1;
          end
        end
        ST_PRESS: begin
          if (!sw_q) begin
            sw_q <= 1'b1;
          end else if (press_cnt_q == 16'd1) begin
            sw_q        <= 1'b0;
            press_cnt_q <= 16'd0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            press_cnt_q <= press_cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign enc_phase_a = a_q;
  assign enc_phase_b = b_q;
  assign enc_switch  = sw_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
